// File: rtl/spi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_ctrl_pkg
// Description : Shared types and constants for the SPI register-access
//               sequencer (spi_reg_ctrl) and its SSEL synchroniser.
//               - state_t    : sequencer state encoding
//               - CMD_RW_BIT : command byte bit selecting read (1) / write (0)
//               - CMD_TX     : default sync marker shifted out during command
//               - BAD_RD     : default data returned for illegal reads
// Revision    : 1.0 - initial release
// ============================================================================
package spi_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD     = 3'd1,
      WR      = 3'd2,
      RD      = 3'd3,
      RD_WAIT = 3'd4
   } state_t;

   localparam int         CMD_RW_BIT = 7;
   localparam logic [7:0] CMD_TX     = 8'hA5;
   localparam logic [7:0] BAD_RD     = 8'hFF;

endpackage : spi_ctrl_pkg
`default_nettype wire

// File: rtl/spi_ssel_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_ssel_sync
// Description : Two-flop synchroniser for the raw, active-low SPI chip select
//               plus edge detection.
// Ports       : clk         - system clock
//               reset       - asynchronous active-low reset
//               ssel        - raw chip select (active low)
//               active      - synchronised chip select asserted
//               start_pulse - one clk on synchronised falling edge
//               end_pulse   - one clk on synchronised rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module spi_ssel_sync (
   input  logic clk,
   input  logic reset,
   input  logic ssel,
   output logic active,
   output logic start_pulse,
   output logic end_pulse
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_armed;

   // The pipeline resets to "selected" and nothing is reported until a
   // synchronised high level has been seen. This way a reset released in
   // the middle of a frame never produces a spurious start; the block waits
   // for the host to deselect and reselect.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_meta  <= 1'b0;
         r_sync  <= 1'b0;
         r_prev  <= 1'b0;
         r_armed <= 1'b0;
      end else begin
         r_meta  <= ssel;
         r_sync  <= r_meta;
         r_prev  <= r_sync;
         r_armed <= r_armed | r_sync;
      end
   end

   assign active      = r_armed & ~r_sync;
   assign start_pulse = r_armed &  r_prev & ~r_sync;
   assign end_pulse   = r_armed & ~r_prev &  r_sync;

endmodule : spi_ssel_sync
`default_nettype wire

// File: rtl/spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_ctrl
// Description : Register-access sequencer behind an SPI slave byte engine.
//               Each SSEL frame is a command byte {rw, addr[6:0]} followed
//               by data bytes. Writes strobe reg_we per data byte; reads
//               strobe reg_re and place the returned data on tx for the
//               next byte shifted out.
// Config      : SPI_CTRL_AUTOINC_EN - when defined the address advances
//               after every data byte (burst, wrapping at 2^ADDR_W); when
//               undefined the address stays at the command value.
// Ports       : clk, reset (async active-low), SSEL (raw, active low),
//               rx/byte_received (from slave), tx (to slave),
//               reg_addr/reg_wdata/reg_we/reg_re/reg_rdata (register bank),
//               frame_active, err (sticky illegal-address), clr_err.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_ctrl
   import spi_ctrl_pkg::*;
#(
   parameter int                ADDR_W   = 7,
   parameter int                DATA_W   = 8,
   parameter int                NUM_REGS = 96,
   parameter logic [DATA_W-1:0] CMD_TX   = spi_ctrl_pkg::CMD_TX,
   parameter logic [DATA_W-1:0] BAD_RD   = spi_ctrl_pkg::BAD_RD
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              SSEL,
   input  logic [DATA_W-1:0] rx,
   input  logic              byte_received,
   output logic [DATA_W-1:0] tx,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              frame_active,
   output logic              err,
   input  logic              clr_err
);

   state_t            r_state;
   logic              r_adv;
   logic              w_frame_start;
   logic              w_frame_end;
   logic              w_addr_ok;
   logic              w_rd_latch;
   logic              w_err_set;
   logic [ADDR_W-1:0] w_addr_next;

   spi_ssel_sync u_ssel_sync (
      .clk         (clk),
      .reset       (reset),
      .ssel        (SSEL),
      .active      (frame_active),
      .start_pulse (w_frame_start),
      .end_pulse   (w_frame_end)
   );

   assign w_addr_ok = (int'(reg_addr) < NUM_REGS);

`ifdef SPI_CTRL_AUTOINC_EN
   localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};
   // Natural modulo-2^ADDR_W wrap; stepping past NUM_REGS is legal and the
   // illegal address is caught at the access.
   assign w_addr_next = reg_addr + c_addr_one;
`else
   assign w_addr_next = reg_addr;
`endif

   // reg_re is still high during the first RD_WAIT cycle; the bank returns
   // data one clk after the strobe, so tx is captured once reg_re has dropped.
   assign w_rd_latch = (r_state == RD_WAIT) && !reg_re;

   always_comb begin
      w_err_set = 1'b0;
      if (!w_frame_end) begin
         if ((r_state == WR) && byte_received && !w_addr_ok)
            w_err_set = 1'b1;
         if (w_rd_latch && !w_addr_ok)
            w_err_set = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_adv     <= 1'b0;
         tx        <= CMD_TX;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         err       <= 1'b0;
      end else begin
         reg_we <= 1'b0;
         reg_re <= 1'b0;
         r_adv  <= 1'b0;
         // A new error in the same cycle as clr_err keeps the flag set.
         err    <= w_err_set | (err & ~clr_err);

         if (w_frame_end) begin
            // Deselect overrides everything, including a byte landing in
            // this very cycle and any read still waiting for data.
            r_state <= IDLE;
            tx      <= CMD_TX;
         end else begin
            case (r_state)
               IDLE: begin
                  tx <= CMD_TX;
                  if (w_frame_start)
                     r_state <= CMD;
               end
               CMD: begin
                  if (byte_received) begin
                     reg_addr <= rx[ADDR_W-1:0];
                     if (rx[CMD_RW_BIT]) begin
                        reg_re  <= 1'b1;
                        r_state <= RD_WAIT;
                     end else begin
                        r_state <= WR;
                     end
                  end
               end
               WR: begin
                  // Address steps the cycle after the strobe so reg_addr is
                  // stable while reg_we is high.
                  if (r_adv)
                     reg_addr <= w_addr_next;
                  if (byte_received) begin
                     reg_wdata <= rx;
                     reg_we    <= w_addr_ok;
                     r_adv     <= 1'b1;
                  end
               end
               RD_WAIT: begin
                  if (w_rd_latch) begin
                     tx       <= w_addr_ok ? reg_rdata : BAD_RD;
                     reg_addr <= w_addr_next;
                     r_state  <= RD;
                  end
               end
               RD: begin
                  if (byte_received) begin
                     reg_re  <= 1'b1;
                     r_state <= RD_WAIT;
                  end
               end
               default: begin
                  r_state <= IDLE;
                  tx      <= CMD_TX;
               end
            endcase
         end
      end
   end

endmodule : spi_reg_ctrl
`default_nettype wire
